grid_loader: RTL and testbench
==============================

// Module: grid_loader
// PURPOSE
//   Upstream stage of the paper-roll accessibility counter. Accepts the puzzle grid as an ASCII
//   byte stream ('@' = paper, '.' = empty, LF = end of row) over a valid/ready handshake and
//   assembles the 1/0 occupancy matrix that the counter consumes. Holds a completed matrix
//   until the consumer acknowledges it, then accepts the next grid.
// PARAMETERS
//   WIDTH  16  max columns per row
//   DEPTH  16  max rows per grid
// PORTS
//   clk         in   1                      clock, all state on rising edge
//   rst_n       in   1                      asynchronous active-low reset
//   in_valid    in   1                      in_data/in_last valid
//   in_ready    out  1                      loader accepts byte (transfer = in_valid & in_ready)
//   in_data     in   8                      ASCII byte
//   in_last     in   1                      final byte of current grid
//   grid_valid  out  1                      matrix/dims stable and complete
//   grid_ack    in   1                      consumer has taken matrix (sampled only while grid_valid)
//   grid_err    out  1                      qualifies grid_valid: grid malformed, matrix undefined
//   mat         out  WIDTH*DEPTH            row i = mat[i*WIDTH +: WIDTH], column j = bit j of row
//   rows        out  $clog2(DEPTH+1)        rows loaded
//   cols        out  $clog2(WIDTH+1)        columns per row (set by row 0)
// BEHAVIOUR
//   Reset: state LOAD; mat, rows, cols, col_cnt = 0; grid_valid = grid_err = 0; in_ready = 0
//     while rst_n low, 1 from first edge after release. Reset mid-grid discards all partial data.
//   States: LOAD (in_ready=1), DRAIN (in_ready=1, bytes discarded), HOLD (in_ready=0, grid_valid=1).
//   LOAD, per accepted byte:
//     '@'/'.': write 1/0 at (rows, col_cnt); col_cnt++. col_cnt==WIDTH before write -> DRAIN.
//       rows==DEPTH before write -> DRAIN.
//     LF (0x0A): col_cnt==0 -> DRAIN (empty line). rows==0: cols<=col_cnt. rows>0 and
//       col_cnt!=cols -> DRAIN (ragged). Else rows++, col_cnt<=0.
//     CR (0x0D): ignored, no state change.
//     any other byte -> DRAIN.
//     in_last on same byte: if col_cnt>0 after the byte (row not LF-terminated) close row with
//       same LF checks; if no error -> HOLD, grid_err=0. in_last on first byte of an empty
//       stream (CR only / nothing loaded) -> HOLD with rows=cols=0.
//   Error on the in_last byte itself goes directly to HOLD with grid_err=1.
//   DRAIN: discard bytes until in_last accepted, then HOLD with grid_err=1.
//   HOLD: outputs frozen. grid_ack=1 -> next cycle LOAD; mat, rows, cols, col_cnt, grid_err
//     cleared; grid_valid=0. grid_ack outside HOLD ignored.
//   Latency: grid_valid rises the cycle after the in_last transfer. Back-to-back: first byte of
//     next grid accepted the cycle after ack (1-cycle bubble, no combinational ack->ready path).
//   Cells outside rows x cols always read 0, so consumer edge logic needs no masking.
//   Counters saturate by construction (error before overflow); no wrap-around possible.
// CONFIGURATION
//   PAPER_COUNT_EN defined: extra port paper_count out $clog2(WIDTH*DEPTH+1): number of '@'
//     accepted into the current grid; increments same cycle as the cell write, cleared on reset
//     and on ack, frozen in HOLD, value undefined when grid_err=1.
//   PAPER_COUNT_EN undefined: port and counter absent; all other behaviour identical.
// TESTING
//   "..@\n@@.\n.@@\n"+in_last on final LF -> grid_valid next cycle, rows=3, cols=3,
//     row0=3'b100, row1=3'b011, row2=3'b110, grid_err=0, (PAPER_COUNT_EN) paper_count=5.
//   "@.\r\n.@" with in_last on final '@' -> rows=2, cols=2, no err; CR ignored, last row closed.
//   "@@@\n@@\n@@@"+in_last -> DRAIN after 2nd LF, bytes absorbed, HOLD with grid_err=1.
//   WIDTH+1 cells in row 0; then 'x' byte in a fresh grid -> both end grid_err=1 after in_last.
//   In HOLD drive in_valid=1 for 5 cycles -> in_ready=0, mat unchanged; pulse grid_ack -> next
//     cycle grid_valid=0, mat=0, in_ready=1.
//   Assert rst_n=0 mid-row -> outputs zero immediately; new 2x2 grid after release loads cleanly.

Source files
------------

// File: rtl/grid_loader.sv
// Assembles an ASCII '@'/'.'/LF grid stream into a WIDTH x DEPTH occupancy matrix held until grid_ack;
// grid_valid rises the cycle after the in_last transfer, in_ready drops in HOLD. PAPER_COUNT_EN adds paper_count.
module grid_loader #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [7:0]                     in_data,
    input  logic                           in_last,
    output logic                           grid_valid,
    input  logic                           grid_ack,
    output logic                           grid_err,
    output logic [WIDTH*DEPTH-1:0]         mat,
    output logic [$clog2(DEPTH+1)-1:0]     rows,
    output logic [$clog2(WIDTH+1)-1:0]     cols
`ifdef PAPER_COUNT_EN
    ,
    output logic [$clog2(WIDTH*DEPTH+1)-1:0] paper_count
`endif
);

    localparam int RW = $clog2(DEPTH+1);
    localparam int CW = $clog2(WIDTH+1);
`ifdef PAPER_COUNT_EN
    localparam int PW = $clog2(WIDTH*DEPTH+1);
`endif
    localparam logic [7:0] CH_AT  = 8'h40;
    localparam logic [7:0] CH_DOT = 8'h2E;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_CR  = 8'h0D;

    typedef enum logic [1:0] {LOAD, DRAIN, HOLD} state_t;

    state_t                 state;
    logic [CW-1:0]          col_cnt;
    logic [CW-1:0]          col_after;
    logic [WIDTH*DEPTH-1:0] mat_wr;
    logic                   xfer;
    logic                   is_cell;
    logic                   is_lf;
    logic                   is_cr;
    logic                   cell_bad;
    logic                   row_bad;
    logic                   close_row;
    logic                   bad;

    always_comb begin
        xfer      = in_valid && in_ready;
        is_cell   = (in_data == CH_AT) || (in_data == CH_DOT);
        is_lf     = (in_data == CH_LF);
        is_cr     = (in_data == CH_CR);
        cell_bad  = (col_cnt == CW'(WIDTH)) || (rows == RW'(DEPTH));
        col_after = (is_cell && !cell_bad) ? col_cnt + CW'(1) : col_cnt;
        row_bad   = (col_after == '0) || ((rows != '0) && (col_after != cols));
        // An in_last on a cell byte closes the unterminated row with the same checks as LF.
        close_row = is_lf || (in_last && (col_after != '0));
        bad       = (is_cell && cell_bad) || (!is_cell && !is_lf && !is_cr) || (close_row && row_bad);

        mat_wr = mat;
        for (int r = 0; r < DEPTH; r++) begin
            for (int c = 0; c < WIDTH; c++) begin
                if ((rows == RW'(r)) && (col_cnt == CW'(c))) begin
                    mat_wr[r*WIDTH + c] = (in_data == CH_AT);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= LOAD;
            in_ready   <= 1'b0;
            grid_valid <= 1'b0;
            grid_err   <= 1'b0;
            mat        <= '0;
            rows       <= '0;
            cols       <= '0;
            col_cnt    <= '0;
`ifdef PAPER_COUNT_EN
            paper_count <= '0;
`endif
        end else begin
            case (state)
                LOAD: begin
                    in_ready <= 1'b1;
                    if (xfer) begin
                        if (is_cell && !cell_bad) begin
                            mat     <= mat_wr;
                            col_cnt <= col_after;
`ifdef PAPER_COUNT_EN
                            if (in_data == CH_AT) paper_count <= paper_count + PW'(1);
`endif
                        end
                        if (close_row && !bad) begin
                            if (rows == '0) cols <= col_after;
                            rows    <= rows + RW'(1);
                            col_cnt <= '0;
                        end
                        if (in_last) begin
                            state      <= HOLD;
                            in_ready   <= 1'b0;
                            grid_valid <= 1'b1;
                            grid_err   <= bad;
                        end else if (bad) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    in_ready <= 1'b1;
                    if (xfer && in_last) begin
                        state      <= HOLD;
                        in_ready   <= 1'b0;
                        grid_valid <= 1'b1;
                        grid_err   <= 1'b1;
                    end
                end
                HOLD: begin
                    if (grid_ack) begin
                        state      <= LOAD;
                        in_ready   <= 1'b1;
                        grid_valid <= 1'b0;
                        grid_err   <= 1'b0;
                        mat        <= '0;
                        rows       <= '0;
                        cols       <= '0;
                        col_cnt    <= '0;
`ifdef PAPER_COUNT_EN
                        paper_count <= '0;
`endif
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_grid_loader.sv
// Scoreboard bench for grid_loader: a line-list reference model predicts each grid, a monitor checks on grid_valid.
`timescale 1ns/1ps
module tb_grid_loader;
    localparam int WIDTH = 16;
    localparam int DEPTH = 16;
    localparam int RW = $clog2(DEPTH+1);
    localparam int CW = $clog2(WIDTH+1);
    localparam int MW = WIDTH*DEPTH;

    typedef logic [MW-1:0] vec_t;
    typedef struct {
        logic err;
        int   nrows;
        int   ncols;
        vec_t m;
        int   pc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          grid_ack = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready;
    logic          grid_valid;
    logic          grid_err;
    vec_t          mat;
    logic [RW-1:0] rows;
    logic [CW-1:0] cols;
`ifdef PAPER_COUNT_EN
    logic [$clog2(MW+1)-1:0] paper_count;
`endif

    exp_t       sb[$];
    logic [7:0] stim[$];
    int         checks = 0;
    int         failures = 0;
    logic       mon_prev = 1'b0;

    grid_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .grid_valid(grid_valid),
        .grid_ack(grid_ack), .grid_err(grid_err), .mat(mat), .rows(rows), .cols(cols)
`ifdef PAPER_COUNT_EN
        , .paper_count(paper_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic checkm(input string name, input vec_t act, input vec_t req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference: split the stream into lines, then judge the line list as a whole.
    function automatic exp_t model();
        exp_t e;
        int   lens[$];
        int   cur;
        cur = 0;
        e.err = 1'b0; e.m = '0; e.pc = 0;
        foreach (stim[i]) begin
            if (stim[i] == 8'h0D) continue;
            if (stim[i] == 8'h0A) begin
                lens.push_back(cur);
                cur = 0;
            end else if (stim[i] == 8'h40 || stim[i] == 8'h2E) begin
                if (lens.size() < DEPTH && cur < WIDTH) e.m[lens.size()*WIDTH + cur] = (stim[i] == 8'h40);
                if (stim[i] == 8'h40) e.pc++;
                cur++;
            end else begin
                e.err = 1'b1;
            end
        end
        if (cur > 0) lens.push_back(cur);
        e.nrows = lens.size();
        e.ncols = (lens.size() > 0) ? lens[0] : 0;
        if (lens.size() > DEPTH) e.err = 1'b1;
        foreach (lens[i]) if (lens[i] == 0 || lens[i] > WIDTH || lens[i] != lens[0]) e.err = 1'b1;
        return e;
    endfunction

    task automatic load_str(input string s);
        stim.delete();
        for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
    endtask

    task automatic drive_byte(input logic [7:0] b, input logic last);
        int budget;
        bit hs;
        budget = 100;
        hs = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        in_valid = 1'b1; in_data = b; in_last = last;
        do begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk); #1;
            budget--;
        end while (!hs && budget > 0);
        check("handshake", int'(hs), 1);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic run_grid(input bit hold_test);
        exp_t e;
        e = model();
        sb.push_back(e);
        foreach (stim[i]) drive_byte(stim[i], i == stim.size() - 1);
        @(negedge clk);
        check("latency_grid_valid", int'(grid_valid), 1);
        for (int k = 0; k < 50 && !grid_valid; k++) @(negedge clk);
        if (hold_test) begin
            check("d1_rows", int'(rows), 3);
            check("d1_cols", int'(cols), 3);
            check("d1_row0", int'(mat[2:0]), 4);
            check("d1_row1", int'(mat[WIDTH+2:WIDTH]), 3);
            check("d1_row2", int'(mat[2*WIDTH+2:2*WIDTH]), 6);
`ifdef PAPER_COUNT_EN
            check("d1_paper_count", int'(paper_count), 5);
`endif
            @(posedge clk); #1;
            in_valid = 1'b1; in_data = 8'h40;
            repeat (5) begin
                @(negedge clk);
                check("hold_in_ready", int'(in_ready), 0);
                checkm("hold_mat", mat, e.m);
            end
            in_valid = 1'b0;
        end
        repeat ($urandom_range(0, 3)) @(posedge clk);
        @(posedge clk); #1; grid_ack = 1'b1;
        @(posedge clk); #1; grid_ack = 1'b0;
        check("ack_grid_valid", int'(grid_valid), 0);
        check("ack_in_ready", int'(in_ready), 1);
        checkm("ack_mat", mat, '0);
        check("ack_rows", int'(rows), 0);
        check("ack_cols", int'(cols), 0);
    endtask

    task automatic gen_random();
        int nr, nc, fault, len;
        nr = $urandom_range(1, DEPTH);
        nc = $urandom_range(1, WIDTH);
        fault = $urandom_range(0, 6);
        stim.delete();
        if (fault == 3) begin
            repeat (WIDTH + 1) stim.push_back(8'h2E);
            stim.push_back(8'h0A);
        end
        for (int r = 0; r < nr; r++) begin
            len = (fault == 1 && r == nr - 1) ? nc + 1 : nc;
            for (int c = 0; c < len; c++) stim.push_back(($urandom_range(0, 1) != 0) ? 8'h40 : 8'h2E);
            if ($urandom_range(0, 3) == 0) stim.push_back(8'h0D);
            if (r < nr - 1 || $urandom_range(0, 1) != 0) stim.push_back(8'h0A);
        end
        if (fault == 2) stim[$urandom_range(0, stim.size() - 1)] = 8'h41 + 8'($urandom_range(0, 25));
        if (fault == 4) begin
            stim.push_back(8'h0A);
            stim.push_back(8'h0A);
        end
    endtask

    // Monitor: compare each newly presented grid against the oldest prediction.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (grid_valid && !mon_prev) begin
                check("sb_nonempty", int'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("grid_err", int'(grid_err), int'(e.err));
                    if (!e.err) begin
                        check("rows", int'(rows), e.nrows);
                        check("cols", int'(cols), e.ncols);
                        checkm("mat", mat, e.m);
`ifdef PAPER_COUNT_EN
                        check("paper_count", int'(paper_count), e.pc);
`endif
                    end
                end
            end
            mon_prev = grid_valid;
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        string s;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_grid_valid", int'(grid_valid), 0);
        check("rst_grid_err", int'(grid_err), 0);
        checkm("rst_mat", mat, '0);
        check("rst_rows", int'(rows), 0);
        check("rst_cols", int'(cols), 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset", int'(in_ready), 1);

        load_str("..@\n@@.\n.@@\n");  run_grid(1'b1);
        load_str("@.\r\n.@");          run_grid(1'b0);
        load_str("@@@\n@@\n@@@");      run_grid(1'b0);
        s = "";
        for (int i = 0; i <= WIDTH; i++) s = {s, "@"};
        load_str({s, "\n"});           run_grid(1'b0);
        load_str("@x@\n");             run_grid(1'b0);
        load_str("\r");                run_grid(1'b0);
        s = "";
        for (int i = 0; i <= DEPTH; i++) s = {s, "@\n"};
        load_str(s);                   run_grid(1'b0);

        drive_byte(8'h40, 1'b0);
        drive_byte(8'h40, 1'b0);
        drive_byte(8'h0A, 1'b0);
        drive_byte(8'h40, 1'b0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midrst_grid_valid", int'(grid_valid), 0);
        check("midrst_in_ready", int'(in_ready), 0);
        checkm("midrst_mat", mat, '0);
        check("midrst_rows", int'(rows), 0);
        check("midrst_cols", int'(cols), 0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        load_str("@.\n.@\n");          run_grid(1'b0);

        for (int g = 0; g < 30; g++) begin
            gen_random();
            run_grid(1'b0);
        end

        repeat (3) @(posedge clk);
        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
